// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: parity modes and receive FSM states.
package uart_pkg;

  localparam int unsigned CHK_NONE = 0;
  localparam int unsigned CHK_EVEN = 1;
  localparam int unsigned CHK_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, realignable.
module uart_baud_tick #(
  parameter int unsigned DIV = 54
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned     CNT_W    = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  if (DIV < 2) begin : g_div_check
    $error("uart_baud_tick: clock divider must be at least 2");
  end

  // Divider counter; restart realigns the tick phase to the start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote, parity and framing checks.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned P_SYSTEM_CLK      = 100000000,
  parameter int unsigned P_UART_BUADRATE   = 115200,
  parameter int unsigned P_OVERSAMPLE      = 16,
  parameter int unsigned P_UART_DATA_WIDTH = 8,
  parameter int unsigned P_UART_STOP_WIDTH = 1,
  parameter int unsigned P_UART_CHECK      = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_uart_rx,
  output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
  output logic                         o_user_rx_valid,
  output logic                         o_user_rx_parity_err,
  output logic                         o_user_rx_frame_err
);

  localparam int unsigned DIV   = P_SYSTEM_CLK / (P_UART_BUADRATE * P_OVERSAMPLE);
  localparam int unsigned OS    = P_OVERSAMPLE;
  localparam int unsigned DW    = P_UART_DATA_WIDTH;
  localparam int unsigned OS_W  = $clog2(OS);
  localparam int unsigned BIT_W = $clog2(DW);

  localparam logic [OS_W-1:0]  SMP_A     = OS_W'(OS / 2 - 1);
  localparam logic [OS_W-1:0]  SMP_B     = OS_W'(OS / 2);
  localparam logic [OS_W-1:0]  SMP_C     = OS_W'(OS / 2 + 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DW - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(P_UART_STOP_WIDTH - 1);

  if (!(OS == 8 || OS == 16)) begin : g_os_check
    $error("uart_rx_os: oversample must be 8 or 16");
  end
  if (DW < 5 || DW > 9) begin : g_dw_check
    $error("uart_rx_os: data width must be 5..9");
  end
  if (!(P_UART_STOP_WIDTH == 1 || P_UART_STOP_WIDTH == 2)) begin : g_stop_check
    $error("uart_rx_os: stop width must be 1 or 2");
  end
  if (P_UART_CHECK > CHK_ODD) begin : g_chk_check
    $error("uart_rx_os: parity mode must be 0, 1 or 2");
  end

  logic rx_meta, rx_sync, rx_prev;
  logic tick, restart_c, fall_c, vote_c, decide_c, bit_end_c;

  state_e            state_q, state_nxt;
  logic [OS_W-1:0]   os_q, os_nxt;
  logic [BIT_W-1:0]  bit_q, bit_nxt;
  logic              smp_a_q, smp_a_nxt, smp_b_q, smp_b_nxt;
  logic [DW-1:0]     shreg_q, shreg_nxt;
  logic              par_q, par_nxt, perr_q, perr_nxt, ferr_q, ferr_nxt;
  logic [DW-1:0]     data_nxt;
  logic              valid_nxt, out_perr_nxt, out_ferr_nxt;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .restart (restart_c),
    .tick    (tick)
  );

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall_c    = rx_prev & ~rx_sync;
  assign vote_c    = (smp_a_q & smp_b_q) | (smp_a_q & rx_sync) | (smp_b_q & rx_sync);
  assign decide_c  = tick & (os_q == SMP_C);
  assign bit_end_c = tick & (os_q == OS_LAST);

  // Next-state and next-output logic for the receive FSM
  always_comb begin
    state_nxt    = state_q;
    os_nxt       = os_q;
    bit_nxt      = bit_q;
    smp_a_nxt    = smp_a_q;
    smp_b_nxt    = smp_b_q;
    shreg_nxt    = shreg_q;
    par_nxt      = par_q;
    perr_nxt     = perr_q;
    ferr_nxt     = ferr_q;
    data_nxt     = o_user_rx_data;
    valid_nxt    = 1'b0;
    out_perr_nxt = o_user_rx_parity_err;
    out_ferr_nxt = o_user_rx_frame_err;
    restart_c    = 1'b0;

    if (state_q != ST_IDLE && tick) begin
      os_nxt = bit_end_c ? '0 : os_q + OS_W'(1);
      if (os_q == SMP_A) smp_a_nxt = rx_sync;
      if (os_q == SMP_B) smp_b_nxt = rx_sync;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall_c) begin
          state_nxt = ST_START;
          os_nxt    = '0;
          bit_nxt   = '0;
          par_nxt   = 1'b0;
          perr_nxt  = 1'b0;
          ferr_nxt  = 1'b0;
          restart_c = 1'b1;
        end
      end
      ST_START: begin
        if (decide_c && vote_c) state_nxt = ST_IDLE;
        else if (bit_end_c)     state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (decide_c) begin
          shreg_nxt = {vote_c, shreg_q[DW-1:1]};
          par_nxt   = par_q ^ vote_c;
        end
        if (bit_end_c) begin
          if (bit_q == DATA_LAST) begin
            bit_nxt   = '0;
            state_nxt = (P_UART_CHECK != CHK_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_nxt = bit_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (decide_c)
          perr_nxt = (P_UART_CHECK == CHK_ODD) ? (vote_c == par_q) : (vote_c != par_q);
        if (bit_end_c) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        // Final stop bit publishes at its decision tick so a back-to-back start is seen
        if (decide_c) begin
          if (bit_q == STOP_LAST) begin
            data_nxt     = shreg_q;
            valid_nxt    = 1'b1;
            out_perr_nxt = perr_q;
            out_ferr_nxt = ferr_q | ~vote_c;
            state_nxt    = ST_IDLE;
          end else begin
            ferr_nxt = ferr_q | ~vote_c;
          end
        end else if (bit_end_c) begin
          bit_nxt = bit_q + BIT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM, datapath and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q              <= ST_IDLE;
      os_q                 <= '0;
      bit_q                <= '0;
      smp_a_q              <= 1'b0;
      smp_b_q              <= 1'b0;
      shreg_q              <= '0;
      par_q                <= 1'b0;
      perr_q               <= 1'b0;
      ferr_q               <= 1'b0;
      o_user_rx_data       <= '0;
      o_user_rx_valid      <= 1'b0;
      o_user_rx_parity_err <= 1'b0;
      o_user_rx_frame_err  <= 1'b0;
    end else begin
      state_q              <= state_nxt;
      os_q                 <= os_nxt;
      bit_q                <= bit_nxt;
      smp_a_q              <= smp_a_nxt;
      smp_b_q              <= smp_b_nxt;
      shreg_q              <= shreg_nxt;
      par_q                <= par_nxt;
      perr_q               <= perr_nxt;
      ferr_q               <= ferr_nxt;
      o_user_rx_data       <= data_nxt;
      o_user_rx_valid      <= valid_nxt;
      o_user_rx_parity_err <= out_perr_nxt;
      o_user_rx_frame_err  <= out_ferr_nxt;
    end
  end

endmodule
